rr_onehot_sched: RTL and testbench
==================================

// Module: rr_onehot_sched
// PURPOSE
// - Round-robin scheduler that serves a wide request vector one bit at a time.
// - Accepts an N-bit request vector and emits each set bit as a one-hot grant
//   plus its binary index, one bit per handshake.
// - Sits in front of the one-hot/binary encode datapath and sequences it.
// - Decoders or consumers downstream see a clean valid/ready stream.
// PARAMETERS
// - N     128           request vector width; power of two, >= 2
// - IDXW  $clog2(N)=7   index width; derived, not overridable
// PORTS
// - clk         in   1     single clock; all state on rising edge
// - rst_n       in   1     asynchronous, active-low reset
// - load_valid  in   1     request vector offered
// - load_ready  out  1     scheduler idle, can take a vector
// - load_vec    in   N     request vector; bit i = requester i
// - flush       in   1     synchronous abort of the current vector
// - out_valid   out  1     a grant is presented
// - out_ready   in   1     consumer takes the grant
// - out_onehot  out  N     grant, exactly one bit set while out_valid
// - out_index   out  IDXW  binary index of the out_onehot bit
// - done        out  1     one-cycle pulse: vector fully served
// - busy        out  1     state != IDLE
// BEHAVIOUR
// - Reset state: IDLE, pending=0, ptr=0. Outputs at reset: load_ready=1, out_valid=0,
//   out_onehot=0, out_index=0, done=0, busy=0.
// - States: IDLE, RUN, DONE.
//   - IDLE: load_ready=1. On load_valid, latch pending<=load_vec. Go to RUN if the
//     vector is non-zero, else to DONE.
//   - RUN: out_valid=1. Grant = first set bit of pending at index >= ptr, searching
//     upward and wrapping past N-1 to 0.
//     - On out_valid&&out_ready: clear that bit and set ptr<=index+1 (mod N).
//     - If the cleared bit was the last one, go to DONE.
//   - DONE: done=1 for exactly one cycle, then IDLE. load_ready=0 in DONE.
// - Latency: vector accepted at edge t; first grant valid in cycle t+1.
//   One grant per cycle while out_ready=1.
// - Done timing: done is asserted the cycle after the final handshake. An empty
//   vector gives done in cycle t+1 and no out_valid.
// - Backpressure: while out_valid && !out_ready, out_onehot and out_index are held
//   stable and pending does not change.
// - ptr persists across vectors for long-term fairness. It is reset only by rst_n.
// - Output timing: outputs are functions of registered state only. There is no
//   combinational path from any input to any output.
// - out_onehot and out_index are 0 whenever out_valid=0.
// - flush: from any state, next state is IDLE and pending<=0; ptr is kept; no done.
//   - flush beats a simultaneous out handshake: that transfer is void and ptr is
//     not advanced.
//   - flush beats a simultaneous load: the vector is dropped.
// - rst_n asserted mid-RUN: immediate return to the reset state. No done pulse.
// - Bits of load_vec are not re-sampled during RUN. New requests wait for IDLE.
// STRUCTURE
// - Shared package rr_sched_pkg holds:
//   - typedef enum logic [1:0] {IDLE, RUN, DONE} sched_state_t
//   - function rr_mask(ptr): a thermometer mask of bits >= ptr
// - Round-robin pick: a two-pass find-first-set, on pending&mask and then on
//   pending. This is computed inside the top module.
// - Sub-module onehot_index_enc #(N): parametric OR-tree one-hot to binary encoder.
//   It drives out_index from out_onehot and replaces any per-value case table.
// TESTING
// - Reset: hold rst_n=0 -> load_ready=1, out_valid=0, out_index=0, done=0.
// - Basic stream: load bits {0,12,127}, out_ready=1.
//   -> indices 0, 12, 127 on three consecutive cycles, then done for one cycle.
// - Wrap/fairness: ptr=13, load bits {5,100}.
//   -> emits 100 then 5; ptr ends at 6.
// - Backpressure: out_ready=0 for 3 cycles on index 12.
//   -> out_index=12 and out_onehot=1<<12 held for 3 cycles; next index after release.
// - Empty vector: load 0 -> done in cycle t+1, out_valid never rises.
// - Abort paths:
//   - flush together with out_ready during RUN -> IDLE next cycle, no done,
//     ptr unchanged.
//   - rst_n low mid-RUN -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/rr_sched_pkg.sv
// rr_sched_pkg
// Shared definitions for the round-robin one-hot scheduler.
//   sched_state_t : scheduler FSM states (IDLE, RUN, DONE)
//   rr_mask(ptr)  : thermometer mask with every bit at position >= ptr set
//   RR_MAX_N      : widest request vector the mask helper can describe
package rr_sched_pkg;

  localparam int RR_MAX_N = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  // The mask is produced at the widest supported size and callers truncate it
  // to their own vector width, so one helper serves any N up to RR_MAX_N.
  function automatic logic [RR_MAX_N-1:0] rr_mask(input int unsigned ptr);
    return {RR_MAX_N{1'b1}} << ptr;
  endfunction

endpackage

// File: rtl/onehot_index_enc.sv
// onehot_index_enc
// Parametric one-hot to binary encoder built as an OR tree.
//   onehot : N-bit input, at most one bit expected set
//   index  : binary position of the set bit (0 when no bit is set)
// Index bit b is the OR of every onehot bit whose position has bit b set,
// so the structure scales with N without a per-value case table.
module onehot_index_enc #(
  parameter  int N    = 128,
  localparam int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    onehot,
  output logic [IDXW-1:0] index
);

  // One OR reduction per output bit over the positions that carry that bit.
  for (genvar b = 0; b < IDXW; b++) begin : g_bit
    logic [N-1:0] sel;
    for (genvar i = 0; i < N; i++) begin : g_sel
      assign sel[i] = onehot[i] & (((i >> b) & 1) == 1);
    end
    assign index[b] = |sel;
  end

endmodule

// File: rtl/rr_onehot_sched.sv
// rr_onehot_sched
// Round-robin scheduler that takes an N-bit request vector and serves its set
// bits one per valid/ready handshake as a one-hot grant plus binary index.
//   clk, rst_n            : clock, asynchronous active-low reset
//   load_valid/load_ready : request vector handshake (load_vec is the vector)
//   flush                 : synchronous abort of the current vector
//   out_valid/out_ready   : grant handshake (out_onehot, out_index)
//   done                  : one-cycle pulse once a vector is fully served
//   busy                  : scheduler is not idle
// All outputs derive from registered state only.
module rr_onehot_sched
  import rr_sched_pkg::*;
#(
  parameter  int N    = 128,
  localparam int IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [N-1:0]    load_vec,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_onehot,
  output logic [IDXW-1:0] out_index,
  output logic            done,
  output logic            busy
);

  sched_state_t    state_q, state_d;
  logic [N-1:0]    pending_q, pending_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [N-1:0]    mask;
  logic [N-1:0]    masked;
  logic [N-1:0]    grant;

  // Isolates the lowest set bit (v & -v): a find-first-set in one-hot form.
  function automatic logic [N-1:0] lowest_set(input logic [N-1:0] v);
    return v & (~v + N'(1));
  endfunction

  // Round-robin pick: first look only at requests at or above the pointer,
  // and fall back to the whole pending set when none remain up there, which
  // is exactly the upward search that wraps from N-1 back to 0.
  always_comb begin
    mask   = N'(rr_mask(32'(ptr_q)));
    masked = pending_q & mask;
    if (|masked) begin
      grant = lowest_set(masked);
    end else begin
      grant = lowest_set(pending_q);
    end
  end

  // The grant is only shown while RUN so the stream is clean (all zero)
  // whenever out_valid is low; the index follows from the encoder.
  assign out_onehot = (state_q == RUN) ? grant : '0;

  onehot_index_enc #(.N(N)) u_enc (
    .onehot (out_onehot),
    .index  (out_index)
  );

  // Next-state and output decode. Flush overrides everything, including a
  // simultaneous load or grant handshake, but leaves the pointer alone so
  // fairness carries over. The pointer moves only on a completed handshake.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    ptr_d      = ptr_q;
    load_ready = 1'b0;
    out_valid  = 1'b0;
    done       = 1'b0;
    busy       = (state_q != IDLE);

    case (state_q)
      IDLE: load_ready = 1'b1;
      RUN:  out_valid  = 1'b1;
      DONE: done       = 1'b1;
      default: ;
    endcase

    if (flush) begin
      state_d   = IDLE;
      pending_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            pending_d = load_vec;
            state_d   = (|load_vec) ? RUN : DONE;
          end
        end
        RUN: begin
          if (out_ready) begin
            pending_d = pending_q & ~grant;
            ptr_d     = out_index + IDXW'(1);
            if ((pending_q & ~grant) == '0) begin
              state_d = DONE;
            end
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers. Reset returns straight to idle with an empty pending set
  // and the pointer at zero; the pointer is otherwise kept across vectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
    end
  end

endmodule

// File: tb/tb_rr_onehot_sched.sv
// tb_rr_onehot_sched
// Self-checking bench for rr_onehot_sched: a table of directed cycles with
// hand-derived expectations, an asynchronous reset sequence, and a random
// phase compared against a behavioural model of the scheduling rules.
module tb_rr_onehot_sched;

  localparam int N    = 128;
  localparam int IDXW = $clog2(N);

  logic            clk;
  logic            rst_n;
  logic            load_valid;
  logic            load_ready;
  logic [N-1:0]    load_vec;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    out_onehot;
  logic [IDXW-1:0] out_index;
  logic            done;
  logic            busy;

  int total;
  int bad;

  rr_onehot_sched #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_vec   (load_vec),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .out_index  (out_index),
    .done       (done),
    .busy       (busy)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: state 0 idle, 1 serving, 2 done pulse.
  int           m_state;
  logic [N-1:0] m_pend;
  int           m_ptr;

  // Next requester: scan upward from the pointer, wrapping modulo N.
  function automatic int model_grant(input logic [N-1:0] pend, input int ptr);
    for (int j = 0; j < N; j++) begin
      if (pend[(ptr + j) % N]) return (ptr + j) % N;
    end
    return -1;
  endfunction

  // Model update follows the scheduling rules directly, reset asynchronously.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0;
      m_pend  <= '0;
      m_ptr   <= 0;
    end else if (flush) begin
      m_state <= 0;
      m_pend  <= '0;
    end else if (m_state == 0) begin
      if (load_valid) begin
        m_pend  <= load_vec;
        m_state <= (load_vec == '0) ? 2 : 1;
      end
    end else if (m_state == 1) begin
      if (out_ready) begin
        m_pend[model_grant(m_pend, m_ptr)] <= 1'b0;
        m_ptr <= (model_grant(m_pend, m_ptr) + 1) % N;
        if ($countones(m_pend) == 1) m_state <= 2;
      end
    end else begin
      m_state <= 0;
    end
  end

  // Single comparison with failure report.
  task automatic checkVal(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Compare every DUT output with what the model says it should be now.
  task automatic checkOutput(input string tag);
    int           g;
    int           eidx;
    logic [N-1:0] eoh;
    g    = model_grant(m_pend, m_ptr);
    eidx = (m_state == 1 && g >= 0) ? g : 0;
    eoh  = '0;
    if (m_state == 1 && g >= 0) eoh[g] = 1'b1;
    checkVal({tag, ".load_ready"}, N'(load_ready), N'(m_state == 0));
    checkVal({tag, ".out_valid"},  N'(out_valid),  N'(m_state == 1));
    checkVal({tag, ".out_onehot"}, out_onehot,     eoh);
    checkVal({tag, ".out_index"},  N'(out_index),  N'(eidx));
    checkVal({tag, ".done"},       N'(done),       N'(m_state == 2));
    checkVal({tag, ".busy"},       N'(busy),       N'(m_state != 0));
  endtask

  // Hand-written expectation check for one set of output values.
  task automatic checkExpect(input string tag, input logic lr, input logic ov, input int idx,
                             input logic dn, input logic bs);
    logic [N-1:0] eoh;
    eoh = '0;
    if (ov) eoh[idx] = 1'b1;
    checkVal({tag, ".load_ready"}, N'(load_ready), N'(lr));
    checkVal({tag, ".out_valid"},  N'(out_valid),  N'(ov));
    checkVal({tag, ".out_onehot"}, out_onehot,     eoh);
    checkVal({tag, ".out_index"},  N'(out_index),  ov ? N'(idx) : N'(0));
    checkVal({tag, ".done"},       N'(done),       N'(dn));
    checkVal({tag, ".busy"},       N'(busy),       N'(bs));
  endtask

  // Drive inputs at the falling edge, run one rising edge, return at the
  // next falling edge where outputs are sampled.
  task automatic applyStimulus(input logic lv, input logic [N-1:0] vec, input logic rdy,
                               input logic fl);
    load_valid = lv;
    load_vec   = vec;
    out_ready  = rdy;
    flush      = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [N-1:0] bv(input int a);
    logic [N-1:0] v;
    v = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  function automatic logic [N-1:0] rand_vec();
    logic [N-1:0] v;
    int           mode;
    v    = {$urandom, $urandom, $urandom, $urandom};
    mode = $urandom_range(0, 3);
    case (mode)
      0: v = '0;
      1: begin
        v = '0;
        for (int k = 0; k < 3; k++) v[$urandom_range(0, N - 1)] = 1'b1;
      end
      2: v = v & {$urandom, $urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom, $urandom};
      default: ;
    endcase
    return v;
  endfunction

  typedef struct {
    logic         lv;
    logic [N-1:0] vec;
    logic         rdy;
    logic         fl;
    logic         e_lr;
    logic         e_ov;
    int           e_idx;
    logic         e_done;
    logic         e_busy;
  } row_t;

  function automatic row_t mk(input logic lv, input logic [N-1:0] vec, input logic rdy,
                              input logic fl, input logic lr, input logic ov, input int idx,
                              input logic dn, input logic bs);
    row_t r;
    r.lv = lv; r.vec = vec; r.rdy = rdy; r.fl = fl;
    r.e_lr = lr; r.e_ov = ov; r.e_idx = idx; r.e_done = dn; r.e_busy = bs;
    return r;
  endfunction

  row_t tbl[32];

  // Main test sequence: reset, directed table, async reset, random phase.
  initial begin
    total = 0;
    bad   = 0;

    // Basic stream {0,12,127} from ptr 0; ptr ends at 0.
    tbl[0]  = mk(1, bv(0) | bv(12) | bv(127), 1, 0,  0, 1, 0,   0, 1);
    tbl[1]  = mk(0, '0, 1, 0,                         0, 1, 12,  0, 1);
    tbl[2]  = mk(0, '0, 1, 0,                         0, 1, 127, 0, 1);
    tbl[3]  = mk(0, '0, 1, 0,                         0, 0, 0,   1, 1);
    tbl[4]  = mk(0, '0, 1, 0,                         1, 0, 0,   0, 0);
    // Backpressure on index 12 for three cycles; ptr ends at 13.
    tbl[5]  = mk(1, bv(5) | bv(12), 0, 0,             0, 1, 5,   0, 1);
    tbl[6]  = mk(0, '0, 1, 0,                         0, 1, 12,  0, 1);
    tbl[7]  = mk(0, '0, 0, 0,                         0, 1, 12,  0, 1);
    tbl[8]  = mk(0, '0, 0, 0,                         0, 1, 12,  0, 1);
    tbl[9]  = mk(0, '0, 0, 0,                         0, 1, 12,  0, 1);
    tbl[10] = mk(0, '0, 1, 0,                         0, 0, 0,   1, 1);
    tbl[11] = mk(0, '0, 0, 0,                         1, 0, 0,   0, 0);
    // Wrap from ptr 13: 100 then 5; ptr ends at 6.
    tbl[12] = mk(1, bv(5) | bv(100), 1, 0,            0, 1, 100, 0, 1);
    tbl[13] = mk(0, '0, 1, 0,                         0, 1, 5,   0, 1);
    tbl[14] = mk(0, '0, 1, 0,                         0, 0, 0,   1, 1);
    tbl[15] = mk(0, '0, 0, 0,                         1, 0, 0,   0, 0);
    // ptr 6 picks 6 before 0; ptr ends at 1.
    tbl[16] = mk(1, bv(0) | bv(6), 1, 0,              0, 1, 6,   0, 1);
    tbl[17] = mk(0, '0, 1, 0,                         0, 1, 0,   0, 1);
    tbl[18] = mk(0, '0, 1, 0,                         0, 0, 0,   1, 1);
    tbl[19] = mk(0, '0, 0, 0,                         1, 0, 0,   0, 0);
    // Empty vector: done next cycle, no grant.
    tbl[20] = mk(1, '0, 1, 0,                         0, 0, 0,   1, 1);
    tbl[21] = mk(0, '0, 0, 0,                         1, 0, 0,   0, 0);
    // Flush with out_ready: no done, ptr stays 1.
    tbl[22] = mk(1, bv(1) | bv(2), 1, 0,              0, 1, 1,   0, 1);
    tbl[23] = mk(0, '0, 1, 1,                         1, 0, 0,   0, 0);
    tbl[24] = mk(1, bv(0) | bv(1), 0, 0,              0, 1, 1,   0, 1);
    tbl[25] = mk(0, '0, 0, 1,                         1, 0, 0,   0, 0);
    // Flush with load: vector dropped.
    tbl[26] = mk(1, bv(3), 0, 1,                      1, 0, 0,   0, 0);
    tbl[27] = mk(0, '0, 0, 0,                         1, 0, 0,   0, 0);
    tbl[28] = mk(1, bv(0) | bv(1), 1, 0,              0, 1, 1,   0, 1);
    tbl[29] = mk(0, '0, 1, 0,                         0, 1, 0,   0, 1);
    tbl[30] = mk(0, '0, 1, 0,                         0, 0, 0,   1, 1);
    tbl[31] = mk(0, '0, 0, 0,                         1, 0, 0,   0, 0);

    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_vec   = '0;
    out_ready  = 1'b0;
    flush      = 1'b0;
    repeat (2) @(negedge clk);
    checkExpect("reset", 1, 0, 0, 0, 0);
    checkOutput("reset_model");
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      applyStimulus(tbl[i].lv, tbl[i].vec, tbl[i].rdy, tbl[i].fl);
      checkExpect($sformatf("row%0d", i), tbl[i].e_lr, tbl[i].e_ov, tbl[i].e_idx,
                  tbl[i].e_done, tbl[i].e_busy);
      checkOutput($sformatf("row%0d_model", i));
    end

    // Reset asserted mid-RUN between clock edges must clear outputs at once.
    applyStimulus(1, bv(7) | bv(9), 0, 0);
    checkExpect("pre_async", 0, 1, 7, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkExpect("async_reset", 1, 0, 0, 0, 0);
    checkOutput("async_reset_model");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, bv(0) | bv(9), 1, 0);
    checkExpect("post_async0", 0, 1, 0, 0, 1);
    applyStimulus(0, '0, 1, 0);
    checkExpect("post_async1", 0, 1, 9, 0, 1);
    applyStimulus(0, '0, 1, 0);
    checkExpect("post_async_done", 0, 0, 0, 1, 1);
    applyStimulus(0, '0, 0, 0);
    checkOutput("post_async_idle");

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(($urandom_range(0, 2) == 0), rand_vec(),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
      checkOutput("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
